// File: rtl/backend_pkg.sv
// Shared types, constants and helpers for backend_cfg_seq and its serial receiver.
// Frame length depends on whether BACKEND_PARITY_EN is defined at build time.
package backend_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_AMP  = 3'd1,
    RST_CORE = 3'd2,
    RO_WARM  = 3'd3,
    READY    = 3'd4
  } seq_state_e;

  // i_clk cycles without any i_sclk edge before a partial frame is discarded
  localparam int unsigned FRAME_TIMEOUT = 32'd64;

  function automatic int unsigned frame_len(input int unsigned ch_w,
                                            input int unsigned gain_w,
                                            input bit          parity_en);
    frame_len = 32'd2 + ch_w + gain_w + (parity_en ? 32'd1 : 32'd0);
  endfunction

  // Even parity bit for a payload (zero-extended to 32 bits)
  function automatic logic even_parity(input logic [31:0] data);
    even_parity = ^data;
  endfunction

endpackage

// File: rtl/backend_serial_rx.sv
// Serial configuration receiver: synchronises i_sclk/i_sdin, assembles frames and
// emits a one-cycle frame_valid. BACKEND_PARITY_EN adds a trailing even-parity bit.
module backend_serial_rx
  import backend_pkg::*;
#(
  parameter int CH_W   = 3,
  parameter int GAIN_W = 3
) (
  input  logic              i_clk,
  input  logic              i_resetbAll,
  input  logic              i_sclk,
  input  logic              i_sdin,
  output logic              o_frame_valid,
  output logic [CH_W-1:0]   o_addr,
  output logic [GAIN_W-1:0] o_gain,
  output logic              o_ibias,
  output logic              o_frame_err
);

`ifdef BACKEND_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  localparam int FLEN   = int'(frame_len(CH_W, GAIN_W, PARITY_ON));
  localparam int PL     = FLEN - 1;             // bits after the start bit
  localparam int DATA_W = CH_W + GAIN_W + 1;
  localparam int BC_W   = $clog2(FLEN);
  localparam int TO_W   = $clog2(FRAME_TIMEOUT);

  logic              sclk_meta_q, sclk_meta_d;
  logic              sclk_sync_q, sclk_sync_d;
  logic              sclk_prev_q, sclk_prev_d;
  logic              sdin_meta_q, sdin_meta_d;
  logic              sdin_sync_q, sdin_sync_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PL-2:0]     shift_q, shift_d;
  logic [TO_W-1:0]   idle_q, idle_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [CH_W-1:0]   addr_q, addr_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic              ibias_q, ibias_d;

  logic              sclk_rise_s;
  logic              sclk_edge_s;
  logic [PL-1:0]     frame_bits_s;
  logic [DATA_W-1:0] payload_s;
  logic              timeout_s;

  // Next-state logic: synchronisers, bit counter, shift register, timeout, decode
  always_comb begin
    sclk_meta_d  = i_sclk;
    sclk_sync_d  = sclk_meta_q;
    sclk_prev_d  = sclk_sync_q;
    sdin_meta_d  = i_sdin;
    sdin_sync_d  = sdin_meta_q;
    sclk_rise_s  = sclk_sync_q & ~sclk_prev_q;
    sclk_edge_s  = sclk_sync_q ^ sclk_prev_q;
    frame_bits_s = {shift_q, sdin_sync_q};
    payload_s    = frame_bits_s[PL-1 -: DATA_W];
    timeout_s    = (bit_cnt_q != '0) && !sclk_edge_s && (idle_q == TO_W'(FRAME_TIMEOUT - 1));

    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    addr_d    = addr_q;
    gain_d    = gain_q;
    ibias_d   = ibias_q;

    if (sclk_rise_s) begin
      if (bit_cnt_q == '0) begin
        // only a 1 opens a frame; idle zeros are ignored
        if (sdin_sync_q) begin
          bit_cnt_d = BC_W'(1);
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end else if (bit_cnt_q == BC_W'(FLEN - 1)) begin
        bit_cnt_d = '0;
        addr_d    = payload_s[DATA_W-1 -: CH_W];
        gain_d    = payload_s[GAIN_W:1];
        ibias_d   = payload_s[0];
        if (PARITY_ON && (even_parity(32'(payload_s)) != frame_bits_s[0])) begin
          err_d = 1'b1;
        end else begin
          valid_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + BC_W'(1);
        shift_d   = frame_bits_s[PL-2:0];
      end
    end else if (timeout_s) begin
      bit_cnt_d = '0;
    end else begin
      bit_cnt_d = bit_cnt_q;
    end

    if (sclk_edge_s || (bit_cnt_q == '0) || timeout_s) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + TO_W'(1);
    end
  end

  // Receiver state registers
  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      sdin_meta_q <= 1'b0;
      sdin_sync_q <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      idle_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      gain_q      <= '0;
      ibias_q     <= 1'b0;
    end else begin
      sclk_meta_q <= sclk_meta_d;
      sclk_sync_q <= sclk_sync_d;
      sclk_prev_q <= sclk_prev_d;
      sdin_meta_q <= sdin_meta_d;
      sdin_sync_q <= sdin_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      idle_q      <= idle_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      gain_q      <= gain_d;
      ibias_q     <= ibias_d;
    end
  end

  assign o_frame_valid = valid_q;
  assign o_frame_err   = err_q;
  assign o_addr        = addr_q;
  assign o_gain        = gain_q;
  assign o_ibias       = ibias_q;

endmodule

// File: rtl/backend_cfg_seq.sv
// NCH-channel backend controller: per-channel gain/bias registers loaded over the
// serial link, plus the GO-triggered power-up sequencer. Parity via BACKEND_PARITY_EN.
module backend_cfg_seq
  import backend_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int GAIN_W   = 3,
  parameter int GAIN_RST = 0,
  parameter int T_AMP    = 8,
  parameter int T_CORE   = 4,
  parameter int T_RO     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_resetbAll,
  input  logic                  i_sclk,
  input  logic                  i_sdin,
  output logic [NCH*GAIN_W-1:0] o_gain,
  output logic [NCH-1:0]        o_Ibias_2x,
  output logic                  o_resetb_amp,
  output logic                  o_resetb_core,
  output logic                  o_enableRO,
  output logic                  o_ready,
  output logic                  o_cfg_err
);

  localparam int CH_W  = $clog2(NCH + 1);
  localparam int CNT_W = $clog2(T_AMP + T_CORE + T_RO + 1);
  localparam logic [CH_W-1:0]       ADDR_GO  = '1;
  localparam logic [NCH*GAIN_W-1:0] GAIN_RV  = {NCH{GAIN_W'(GAIN_RST)}};

  logic              rx_valid_s;
  logic [CH_W-1:0]   rx_addr_s;
  logic [GAIN_W-1:0] rx_gain_s;
  logic              rx_ibias_s;
  logic              rx_err_s;
  logic              go_s;

  logic [NCH*GAIN_W-1:0] gain_q, gain_d;
  logic [NCH-1:0]        ibias_q, ibias_d;
  logic                  cfg_err_q, cfg_err_d;
  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      dwell_q, dwell_d;
  logic                  amp_q, amp_d;
  logic                  core_q, core_d;
  logic                  ro_q, ro_d;
  logic                  rdy_q, rdy_d;

  backend_serial_rx #(
    .CH_W   (CH_W),
    .GAIN_W (GAIN_W)
  ) u_rx (
    .i_clk         (i_clk),
    .i_resetbAll   (i_resetbAll),
    .i_sclk        (i_sclk),
    .i_sdin        (i_sdin),
    .o_frame_valid (rx_valid_s),
    .o_addr        (rx_addr_s),
    .o_gain        (rx_gain_s),
    .o_ibias       (rx_ibias_s),
    .o_frame_err   (rx_err_s)
  );

  assign go_s = rx_valid_s && (rx_addr_s == ADDR_GO);

  // Channel register writes; addresses in [NCH, ADDR_GO) match no channel and drop out
  always_comb begin
    gain_d    = gain_q;
    ibias_d   = ibias_q;
    cfg_err_d = cfg_err_q | rx_err_s;
    for (int c = 0; c < NCH; c++) begin
      if (rx_valid_s && (int'(rx_addr_s) == c)) begin
        gain_d[c*GAIN_W +: GAIN_W] = rx_gain_s;
        ibias_d[c]                 = rx_ibias_s;
      end else begin
        gain_d[c*GAIN_W +: GAIN_W] = gain_q[c*GAIN_W +: GAIN_W];
        ibias_d[c]                 = ibias_q[c];
      end
    end
  end

  // Channel and error registers
  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      gain_q    <= GAIN_RV;
      ibias_q   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      gain_q    <= gain_d;
      ibias_q   <= ibias_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Sequencer next state; GO wins from any state and restarts the dwell count
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    if (go_s) begin
      state_d = RST_AMP;
      dwell_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
          dwell_d = '0;
        end
        RST_AMP: begin
          if (dwell_q == CNT_W'(T_AMP - 1)) begin
            state_d = RST_CORE;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + CNT_W'(1);
          end
        end
        RST_CORE: begin
          if (dwell_q == CNT_W'(T_CORE - 1)) begin
            state_d = RO_WARM;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + CNT_W'(1);
          end
        end
        RO_WARM: begin
          if (dwell_q == CNT_W'(T_RO - 1)) begin
            state_d = READY;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + CNT_W'(1);
          end
        end
        READY: begin
          state_d = READY;
          dwell_d = '0;
        end
        default: begin
          state_d = IDLE;
          dwell_d = '0;
        end
      endcase
    end

    // outputs decoded from the next state so they register alongside it
    case (state_d)
      RST_CORE: begin amp_d = 1'b1; core_d = 1'b0; ro_d = 1'b0; rdy_d = 1'b0; end
      RO_WARM:  begin amp_d = 1'b1; core_d = 1'b1; ro_d = 1'b1; rdy_d = 1'b0; end
      READY:    begin amp_d = 1'b1; core_d = 1'b1; ro_d = 1'b1; rdy_d = 1'b1; end
      default:  begin amp_d = 1'b0; core_d = 1'b0; ro_d = 1'b0; rdy_d = 1'b0; end
    endcase
  end

  // Sequencer state and registered control outputs
  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      state_q <= IDLE;
      dwell_q <= '0;
      amp_q   <= 1'b0;
      core_q  <= 1'b0;
      ro_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      amp_q   <= amp_d;
      core_q  <= core_d;
      ro_q    <= ro_d;
      rdy_q   <= rdy_d;
    end
  end

  assign o_gain        = gain_q;
  assign o_Ibias_2x    = ibias_q;
  assign o_resetb_amp  = amp_q;
  assign o_resetb_core = core_q;
  assign o_enableRO    = ro_q;
  assign o_ready       = rdy_q;
  assign o_cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_backend_cfg_seq.sv
// Self-checking bench for backend_cfg_seq: directed and random serial frames checked
// every cycle against a behavioural model (channel arrays plus time-since-GO).
module tb_backend_cfg_seq;

  localparam int NCH    = 4;
  localparam int GAIN_W = 3;
  localparam int CH_W   = 3;
  localparam int T_AMP  = 8;
  localparam int T_CORE = 4;
  localparam int T_RO   = 16;
  localparam int HALF   = 4;
  localparam int LAT    = 4;
`ifdef BACKEND_PARITY_EN
  localparam int FLEN = 2 + CH_W + GAIN_W + 1;
`else
  localparam int FLEN = 2 + CH_W + GAIN_W;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rstb, sclk, sdin;
  logic [NCH*GAIN_W-1:0] o_gain;
  logic [NCH-1:0]        o_ib;
  logic                  amp, core, ro, rdy, err;

  backend_cfg_seq #(
    .NCH(NCH), .GAIN_W(GAIN_W), .GAIN_RST(0), .T_AMP(T_AMP), .T_CORE(T_CORE), .T_RO(T_RO)
  ) dut (
    .i_clk(clk), .i_resetbAll(rstb), .i_sclk(sclk), .i_sdin(sdin),
    .o_gain(o_gain), .o_Ibias_2x(o_ib), .o_resetb_amp(amp), .o_resetb_core(core),
    .o_enableRO(ro), .o_ready(rdy), .o_cfg_err(err)
  );

  int errors = 0;
  int checks = 0;

  // reference model
  logic [GAIN_W-1:0] m_gain [NCH];
  logic              m_ib   [NCH];
  int                seq_t;          // cycles since sequence start, -1 = never started
  bit                m_err;
  int                pend_cnt;
  int                pend_addr;
  logic [GAIN_W-1:0] pend_gain;
  logic              pend_ib;
  bit                pend_bad;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_gain[c] = '0;
      m_ib[c]   = 1'b0;
    end
    seq_t    = -1;
    m_err    = 1'b0;
    pend_cnt = 0;
  endtask

  task automatic apply_pending();
    if (pend_bad) m_err = 1'b1;
    else if (pend_addr < NCH) begin
      m_gain[pend_addr] = pend_gain;
      m_ib[pend_addr]   = pend_ib;
    end else if (pend_addr == (1 << CH_W) - 1) seq_t = 0;
  endtask

  task automatic check_all(input string tag);
    logic [NCH*GAIN_W-1:0] eg;
    logic [NCH-1:0]        eb;
    logic [4:0]            ec, oc;
    for (int c = 0; c < NCH; c++) begin
      eg[c*GAIN_W +: GAIN_W] = m_gain[c];
      eb[c]                  = m_ib[c];
    end
    ec = {seq_t >= T_AMP, seq_t >= T_AMP + T_CORE, seq_t >= T_AMP + T_CORE,
          seq_t >= T_AMP + T_CORE + T_RO, m_err};
    oc = {amp, core, ro, rdy, err};
    checks++;
    assert (o_gain === eg && o_ib === eb) else begin
      errors++;
      $error("FAIL %s_chan: observed gain=%h ibias=%b expected gain=%h ibias=%b", tag, o_gain, o_ib, eg, eb);
    end
    checks++;
    assert (oc === ec) else begin
      errors++;
      $error("FAIL %s_ctrl: observed amp/core/ro/rdy/err=%b expected %b (t=%0d)", tag, oc, ec, seq_t);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (seq_t >= 0 && seq_t < 1000) seq_t++;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) apply_pending();
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input bit commit,
                           input int addr, input logic [GAIN_W-1:0] g, input logic ib, input bit bad);
    for (int i = n - 1; i >= 0; i--) begin
      sdin = bits[i];
      sclk = 1'b0;
      repeat (HALF) tick("bit_lo");
      sclk = 1'b1;
      if (i == 0 && commit) begin
        pend_cnt  = LAT;
        pend_addr = addr;
        pend_gain = g;
        pend_ib   = ib;
        pend_bad  = bad;
      end
      repeat (HALF) tick("bit_hi");
    end
    sclk = 1'b0;
    sdin = 1'b0;
    repeat (HALF) tick("frame_end");
  endtask

  task automatic send_frame(input int addr, input logic [GAIN_W-1:0] g, input logic ib, input bit bad);
    logic [15:0]     b;
    logic [CH_W-1:0] a;
    a = CH_W'(addr);
    b = '0;
`ifdef BACKEND_PARITY_EN
    b[FLEN-1:0] = {1'b1, a, g, ib, (^{a, g, ib}) ^ bad};
`else
    b[FLEN-1:0] = {1'b1, a, g, ib};
`endif
    send_bits(b, FLEN, 1'b1, addr, g, ib, bad);
  endtask

  initial begin
    logic [15:0]       hb;
    logic [GAIN_W-1:0] rg;
    logic              rb;
    int                ra;

    rstb = 1'b0;
    sclk = 1'b0;
    sdin = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    repeat (3) tick("reset_hold");
    rstb = 1'b1;
    repeat (20) tick("idle");

    // single channel write, sequencer untouched
    send_frame(2, 3'd5, 1'b1, 1'b0);
    repeat (5) tick("ch2_write");

    // first GO and full sequence, then GO again from READY
    send_frame(7, 3'd2, 1'b1, 1'b0);
    repeat (35) tick("seq1");
    send_frame(7, 3'd0, 1'b0, 1'b0);
    repeat (35) tick("seq2");

    // partial frame abandoned by timeout, then a full write to channel 1
    hb = 16'h000A;
    send_bits(hb, 4, 1'b0, 0, 3'd0, 1'b0, 1'b0);
    repeat (80) tick("timeout_gap");
    send_frame(1, 3'd3, 1'b0, 1'b0);

    // a lone zero-bit clock in idle must not open a frame
    sdin = 1'b0;
    sclk = 1'b1;
    repeat (HALF) tick("noise_hi");
    sclk = 1'b0;
    repeat (HALF) tick("noise_lo");

    // random frames, including reserved addresses and GO
    for (int k = 0; k < 24; k++) begin
      ra = int'($urandom_range(0, 7));
      rg = GAIN_W'($urandom_range(0, 7));
      rb = 1'($urandom_range(0, 1));
      send_frame(ra, rg, rb, 1'b0);
      repeat ($urandom_range(0, 40)) tick("rand_gap");
    end

`ifdef BACKEND_PARITY_EN
    send_frame(0, ~m_gain[0], 1'b1, 1'b1);
    repeat (10) tick("par_err");
    send_frame(3, 3'd4, 1'b1, 1'b0);
    repeat (10) tick("par_sticky");
`endif

    // asynchronous reset mid-sequence and mid-frame
    send_frame(7, 3'd1, 1'b0, 1'b0);
    repeat (10) tick("pre_reset");
    hb = 16'h0006;
    send_bits(hb, 3, 1'b0, 0, 3'd0, 1'b0, 1'b0);
    rstb = 1'b0;
    model_reset();
    #1;
    check_all("reset_async_mid");
    repeat (3) tick("reset_hold2");
    rstb = 1'b1;
    repeat (5) tick("post_reset");
    send_frame(3, 3'd6, 1'b1, 1'b0);
    repeat (5) tick("post_reset_write");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
